// File: rtl/serial_right_shifter_if.sv
// ============================================================================
// Module      : serial_right_shifter_if
// Description : Upstream/downstream valid-ready bundle for serial_right_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_right_shifter_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         up_valid;
  logic         up_ready;
  logic [N-1:0] up_data;
  logic [W-1:0] up_shamt;
  logic         up_arith;
  logic         down_valid;
  logic         down_ready;
  logic [N-1:0] down_data;

  modport master (
    output up_valid, up_data, up_shamt, up_arith, down_ready,
    input  up_ready, down_valid, down_data
  );

  modport slave (
    input  up_valid, up_data, up_shamt, up_arith, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

`default_nettype wire

// File: rtl/serial_right_shifter.sv
// ============================================================================
// Module      : serial_right_shifter
// Description : Sequential right shifter, one bit per clock, valid/ready on
//               both sides. Define SERIAL_RIGHT_SHIFTER_ARITH_EN to honor
//               up_arith (sign fill); otherwise the fill is always zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_right_shifter #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_right_shifter_if.slave  bus
);
  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_shreg;
  logic [W-1:0] r_count;
  logic         r_up_ready;
  logic         r_down_valid;
  logic         w_fill;
  logic         w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.up_valid;

`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
  logic r_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_fill <= bus.up_arith & bus.up_data[N-1];
    end
  end

  assign w_fill = r_fill;
`else
  logic w_unused_arith;

  assign w_unused_arith = bus.up_arith;
  assign w_fill         = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.up_valid) begin
          w_state_nxt = (bus.up_shamt != '0) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (r_count == W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.down_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so neither output
  // has a combinational path from any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_up_ready   <= 1'b1;
      r_down_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_up_ready   <= (w_state_nxt == S_IDLE);
      r_down_valid <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.up_valid) begin
            r_shreg <= bus.up_data;
            r_count <= bus.up_shamt;
          end
        end
        S_BUSY: begin
          r_shreg <= {w_fill, r_shreg[N-1:1]};
          r_count <= r_count - W'(1);
        end
        default: begin
          r_shreg <= r_shreg;
          r_count <= r_count;
        end
      endcase
    end
  end

  assign bus.up_ready   = r_up_ready;
  assign bus.down_valid = r_down_valid;
  assign bus.down_data  = r_shreg;

endmodule

`default_nettype wire

// File: tb/tb_serial_right_shifter.sv
// ============================================================================
// Module      : tb_serial_right_shifter
// Description : Scoreboard bench for serial_right_shifter (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_right_shifter;
  localparam int N = 8;
  localparam int W = $clog2(N);
`ifdef SERIAL_RIGHT_SHIFTER_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] data;
    int           shamt;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   first_seen = -1;
  bit   ready_next = 1'b0;
  bit   rnd_rdy = 1'b0;
  bit   hold_valid = 1'b0;
  exp_t q[$];

  serial_right_shifter_if #(.N(N)) bus ();

  serial_right_shifter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain shift of the operand, sign-filled by complementing around a logical shift.
  function automatic logic [N-1:0] model(input logic [N-1:0] d, input int s, input logic a);
    logic [N-1:0] r;
    r = d >> s;
    if (ARITH && a && d[N-1]) r = ~((~d) >> s);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and scoreboard; sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      first_seen = -1;
      ready_next = 1'b0;
    end else begin
      if (ready_next) chk("up_ready_after_handshake", 64'(bus.up_ready), 64'd1);
      ready_next = 1'b0;
      if (bus.down_valid) begin
        if (first_seen < 0) first_seen = cyc;
        if (q.size() == 0) begin
          chk("unexpected_result", 64'(bus.down_valid), 64'd0);
        end else begin
          chk("up_ready_in_done", 64'(bus.up_ready), 64'd0);
          if (bus.down_ready) begin
            e = q.pop_front();
            chk("result_data", 64'(bus.down_data), 64'(e.data));
            chk("result_latency", 64'(first_seen - e.acc), 64'(e.shamt + 1));
            first_seen = -1;
            ready_next = 1'b1;
          end else begin
            chk("held_data", 64'(bus.down_data), 64'(q[0].data));
          end
        end
      end
      if (bus.up_valid && bus.up_ready) begin
        if (q.size() != 0) chk("accept_while_pending", 64'(q.size()), 64'd0);
        e.data  = model(bus.up_data, int'(bus.up_shamt), bus.up_arith);
        e.shamt = int'(bus.up_shamt);
        e.acc   = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.down_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [N-1:0] d, input int s, input logic a);
    int t = 0;
    bus.up_data  = d;
    bus.up_shamt = W'(s);
    bus.up_arith = a;
    bus.up_valid = 1'b1;
    @(negedge clk);
    while (!bus.up_ready) begin
      t++;
      if (t > 60) begin
        chk("accept_timeout", 64'(bus.up_ready), 64'd1);
        bus.up_valid = 1'b0;
        return;
      end
      tick();
      @(negedge clk);
    end
    tick();
    if (!hold_valid) bus.up_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    rnd_rdy = 1'b0;
    bus.down_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 30) begin
      tick();
      t++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int t;
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_shamt   = '0;
    bus.up_arith   = 1'b0;
    bus.down_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_up_ready", 64'(bus.up_ready), 64'd1);
    chk("reset_down_valid", 64'(bus.down_valid), 64'd0);
    chk("reset_down_data", 64'(bus.down_data), 64'd0);
    tick();

    // Directed patterns.
    send(8'hB4, 3, 1'b0); drain();
    send(8'hB4, 3, 1'b1); drain();
    send(8'hB4, 0, 1'b0); drain();
    send(8'h80, 7, 1'b0); drain();
    send(8'h80, 7, 1'b1); drain();

    // Backpressure: hold result for 5 cycles while a new operand is offered.
    bus.down_ready = 1'b0;
    send(8'hB4, 3, 1'b0);
    t = 0;
    @(negedge clk);
    while (!bus.down_valid && t < 20) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk("bp_result_present", 64'(bus.down_valid), 64'd1);
    tick();
    bus.up_valid = 1'b1;
    bus.up_data  = 8'h55;
    repeat (4) tick();
    bus.up_valid = 1'b0;
    bus.down_ready = 1'b1;
    drain();

    // Reset in the second BUSY cycle discards the operand.
    send(8'hB4, 3, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midbusy_rst_up_ready", 64'(bus.up_ready), 64'd1);
    chk("midbusy_rst_down_valid", 64'(bus.down_valid), 64'd0);
    chk("midbusy_rst_down_data", 64'(bus.down_data), 64'd0);
    repeat (12) tick();

    // Back-to-back with up_valid held high.
    hold_valid = 1'b1;
    send(N'($urandom), 1, 1'($urandom_range(0, 1)));
    send(N'($urandom), 0, 1'($urandom_range(0, 1)));
    send(N'($urandom), 2, 1'($urandom_range(0, 1)));
    send(N'($urandom), 7, 1'($urandom_range(0, 1)));
    hold_valid = 1'b0;
    bus.up_valid = 1'b0;
    drain();

    // Random operands with random downstream backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(N'($urandom), int'($urandom_range(0, N-1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    drain();

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_right_shifter.md
# serial_right_shifter

Multi-cycle, parameterized right shifter with valid/ready handshakes on both sides. It accepts an N-bit operand and a variable shift amount, then shifts one bit position per clock in a small state machine. It presents the result downstream and holds it until accepted. It is the variable-amount, right-direction, sequential counterpart to the team's constant left-shift combinational blocks, and sits in the pipe exercises between an upstream producer and a downstream consumer.

## Interface

Parameters:
- N, default 8: operand and result width; legal values are N >= 2.
- W, default $clog2(N): shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  upstream has an operand.
- up_ready  output  1  block can accept an operand.
- up_data  input  N  operand.
- up_shamt  input  W  shift amount, 0..N-1.
- up_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); honored only per Configuration.
- down_valid  output  1  result available.
- down_ready  input  1  downstream accepts the result.
- down_data  output  N  shifted result.

## Operation

- The state machine has three states:
  - IDLE: up_ready=1, down_valid=0.
  - BUSY: up_ready=0, down_valid=0.
  - DONE: up_ready=0, down_valid=1.
- Accept: in IDLE, if up_valid && up_ready, the block does the following:
  - Latches up_data into the shift register, up_shamt into the remaining-count register, and the fill bit (up_arith ? up_data[N-1] : 0).
  - Next state is BUSY if up_shamt != 0, otherwise DONE.
- BUSY behaviour, each cycle:
  - reg <= {fill, reg[N-1:1]}, and count <= count - 1.
  - When count == 1 at that edge, the next state is DONE.
- DONE: down_data = reg. down_data and down_valid stay stable while down_ready=0. When down_valid && down_ready, the next state is IDLE.
- No accept occurs in the same cycle as a DONE handshake, because up_ready is 0 in DONE.
- Inputs are ignored outside IDLE.
- In IDLE and BUSY, down_data is don't-care; the implementation drives reg.
- Arithmetic: unsigned count. up_shamt values >= N are illegal for non-power-of-two N; the block need not check them, and behaviour is then a result of all fill bits after N shifts.
- Reset: synchronous and active-high. It overrides any state, including mid-BUSY and in DONE with a pending result; the operand in flight is discarded. Reset values:
  - state = IDLE, up_ready = 1, down_valid = 0.
  - down_data = 0, shift register = 0, count = 0, fill = 0.

## Timing

- Latency: an accept at edge k gives down_valid=1 in the cycle after edge k+up_shamt+1 (up_shamt+1 cycles later).
- up_shamt=0 gives down_valid one cycle after accept, with down_data = operand.
- Throughput, with down_ready held at 1: one operand per (up_shamt + 2) cycles, counting accept, up_shamt BUSY cycles and the DONE cycle.
- up_ready is a registered function of state only; there is no combinational path from down_ready to up_ready.
- down_data is registered; there is no combinational path from up_data to down_data.

## Configuration

- Macro SERIAL_RIGHT_SHIFTER_ARITH_EN.
- Defined: up_arith is honored and fill = up_data[N-1] when up_arith=1.
- Undefined: the fill bit is constant 0, up_arith is unused (lint waiver), and the fill register is removed.

## Test plan

- N=8, up_data=0xB4, up_shamt=3, up_arith=0, down_ready=1 → down_valid rises 4 cycles after accept with down_data=0x16, and up_ready returns to 1 the cycle after the handshake.
- Same stimulus with up_arith=1 → 0xF6 when SERIAL_RIGHT_SHIFTER_ARITH_EN is defined, 0x16 when it is undefined.
- up_data=0xB4, up_shamt=0 → down_data=0xB4 one cycle after accept; up_data=0x80, up_shamt=7 → logical result 0x01, arithmetic result 0xFF (macro on).
- Backpressure: result 0x16 pending with down_ready=0 for 5 cycles → down_valid=1 and down_data=0x16 stable and up_ready=0 throughout; a new up_valid is ignored; handshake on cycle 6 → IDLE.
- rst asserted for 1 cycle during BUSY (accept 0xB4, shamt 3, rst at the 2nd BUSY cycle) → next cycle state IDLE, up_ready=1, down_valid=0, down_data=0; no result is ever emitted for that operand.
- Back-to-back: 4 operands with up_valid held high and down_ready=1, shamts 1,0,2,7 → results in order, spaced 3,2,4,9 cycles apart, each matching the >> reference model.
